// File: rtl/hps_ext_pkg.sv
// Shared constants and types for the EXT_BUS initiator: opcodes, request encoding and FSM states.
package hps_ext_pkg;

    localparam logic [7:0] OPC_STATS = 8'h33;
    localparam logic [7:0] OPC_GET   = 8'h34;
    localparam logic [7:0] OPC_SET   = 8'h35;
    localparam logic [7:0] OPC_DATA  = 8'h36;

    localparam int CD_WORDS = 7;

    typedef enum logic [1:0] {
        OP_STATS = 2'd0,
        OP_GET   = 2'd1,
        OP_SET   = 2'd2,
        OP_DATA  = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_GAP,
        ST_FETCH,
        ST_CLOSE
    } state_e;

    function automatic logic [15:0] opcode_word(cmd_op_e op);
        logic [7:0] opc;
        case (op)
            OP_STATS: opc = OPC_STATS;
            OP_GET:   opc = OPC_GET;
            OP_SET:   opc = OPC_SET;
            default:  opc = OPC_DATA;
        endcase
        return {8'h00, opc};
    endfunction

endpackage

// File: rtl/hps_ext_timer.sv
// Loadable down-counter shared by the SETUP, GAP and CLOSE phases; done while the count is zero.
module hps_ext_timer #(
    parameter int W = 8
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/hps_ext_master.sv
// EXT_BUS command initiator standing in for the HPS; the platform wrapper packs these
// outputs into EXT_BUS[34:33,31:16] and returns io_dout/dout_en from EXT_BUS[32,15:0].
module hps_ext_master #(
    parameter int STROBE_GAP = 3,
    parameter int SETUP_CYC  = 1,
    parameter int IDLE_CYC   = 2
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic         cmd_req,
    input  logic [1:0]   cmd_op,
    output logic         cmd_ack,
    output logic         busy,
    input  logic         stats_en,
    input  logic [111:0] set_payload,
    input  logic [15:0]  data_len,
    input  logic [15:0]  data_word,
    input  logic         data_valid,
    output logic         data_ready,
    output logic [111:0] get_payload,
    output logic [7:0]   get_req_cnt,
    output logic         get_new,
    output logic [15:0]  io_din,
    output logic         io_strobe,
    output logic         io_enable,
    input  logic [15:0]  io_dout,
    input  logic         dout_en
);

    import hps_ext_pkg::*;

    localparam logic [7:0] LD_SETUP = 8'(SETUP_CYC - 1);
    localparam logic [7:0] LD_GAP   = 8'(STROBE_GAP - 2);
    localparam logic [7:0] LD_CLOSE = 8'(IDLE_CYC - 1);

    state_e        state, state_nxt;
    cmd_op_e       op_q;
    logic          stats_en_q;
    logic [111:0]  set_q;
    logic [15:0]   len_q;
    logic [16:0]   k, k_inc, word_cnt;
    logic [7:0]    prev_cnt;
    logic          last_word;
    logic          tmr_load, tmr_done;
    logic [7:0]    tmr_val;

    // dout_en is observed by the platform only; the captured word never depends on it.
    logic unused_dout_en;
    assign unused_dout_en = dout_en;

    hps_ext_timer #(.W(8)) u_timer (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Words that are not streamed: opcode, STATS enable, SET payload (GET sends zeros).
    function automatic logic [15:0] fixed_word(cmd_op_e op, logic [16:0] idx, logic se,
                                               logic [111:0] pay);
        logic [15:0] w;
        w = '0;
        if (idx == '0)
            w = opcode_word(op);
        else if (op == OP_STATS)
            w = {15'b0, se};
        else if (op == OP_SET)
            for (int i = 1; i <= CD_WORDS; i++)
                if (idx == 17'(i)) w = pay[16*i-1 -: 16];
        return w;
    endfunction

    always_comb begin
        case (op_q)
            OP_STATS: word_cnt = 17'd2;
            OP_DATA:  word_cnt = {1'b0, len_q} + 17'd1;
            default:  word_cnt = 17'(CD_WORDS + 1);
        endcase
    end

    assign k_inc     = k + 17'd1;
    assign last_word = (k_inc == word_cnt);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        state_nxt  = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        io_enable  = 1'b0;
        io_strobe  = 1'b0;
        busy       = 1'b1;
        data_ready = 1'b0;
        cmd_ack    = 1'b0;
        get_new    = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (cmd_req) begin
                    state_nxt = ST_SETUP;
                    tmr_load  = 1'b1;
                    tmr_val   = LD_SETUP;
                end
            end
            ST_SETUP: begin
                io_enable = 1'b1;
                if (tmr_done) state_nxt = ST_STROBE;
            end
            ST_STROBE: begin
                io_enable = 1'b1;
                io_strobe = 1'b1;
                state_nxt = ST_GAP;
                tmr_load  = 1'b1;
                tmr_val   = LD_GAP;
            end
            ST_GAP: begin
                io_enable = 1'b1;
                if (tmr_done) begin
                    if (last_word) begin
                        state_nxt = ST_CLOSE;
                        tmr_load  = 1'b1;
                        tmr_val   = LD_CLOSE;
                    end else if (op_q == OP_DATA) begin
                        state_nxt = ST_FETCH;
                    end else begin
                        state_nxt = ST_STROBE;
                    end
                end
            end
            ST_FETCH: begin
                io_enable  = 1'b1;
                data_ready = 1'b1;
                if (data_valid) state_nxt = ST_STROBE;
            end
            ST_CLOSE: begin
                if (tmr_done) begin
                    state_nxt = ST_IDLE;
                    cmd_ack   = 1'b1;
                    get_new   = (op_q == OP_GET) && (get_req_cnt != prev_cnt);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            op_q        <= OP_STATS;
            stats_en_q  <= 1'b0;
            set_q       <= '0;
            len_q       <= '0;
            k           <= '0;
            io_din      <= '0;
            get_payload <= '0;
            get_req_cnt <= '0;
            prev_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_req) begin
                        op_q       <= cmd_op_e'(cmd_op);
                        stats_en_q <= stats_en;
                        set_q      <= set_payload;
                        len_q      <= data_len;
                        k          <= '0;
                    end
                end
                ST_SETUP: begin
                    if (tmr_done) io_din <= fixed_word(op_q, '0, stats_en_q, set_q);
                end
                ST_GAP: begin
                    if (tmr_done) begin
                        // Last gap cycle: the responder's answer to word k is stable now.
                        if (op_q == OP_GET) begin
                            if (k == '0) get_req_cnt <= io_dout[7:0];
                            for (int i = 1; i <= CD_WORDS; i++)
                                if (k == 17'(i)) get_payload[16*i-1 -: 16] <= io_dout;
                        end
                        k <= k_inc;
                        if (last_word)
                            io_din <= '0;
                        else if (op_q != OP_DATA)
                            io_din <= fixed_word(op_q, k_inc, stats_en_q, set_q);
                    end
                end
                ST_FETCH: begin
                    if (data_valid) io_din <= data_word;
                end
                ST_CLOSE: begin
                    if (tmr_done && op_q == OP_GET) prev_cnt <= get_req_cnt;
                end
                default: ;
            endcase
        end
    end

endmodule
